// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   PC register, next-PC selection and instruction-fetch handshake for the
//   RV32 core. The current PC is presented to imem; the returned word is
//   latched as instr and held until the core retires it. On retire, the next
//   PC is chosen from jalr / branch-or-jal / sequential, in that priority.
//   A fetch timeout or a misaligned target parks the unit in a sticky error
//   state until reset.
//
// Build option:
//   RETIRE_CNT_EN  when defined, instret counts retired instructions
//                  (wrapping at 2^32); when undefined instret is tied to 0
//                  and no counter flops exist.
//
// Parameters:
//   RESET_PC       PC loaded on reset
//   FETCH_TIMEOUT  REQ cycles without imem_ack before error (1..255)
//
// Ports:
//   clk          core clock, all state on posedge
//   reset        synchronous, active-low reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    fetch address (= pc)
//   imem_ack     imem_rdata valid this cycle
//   imem_rdata   fetched instruction word
//   instr        latched instruction for decode
//   instr_valid  instr valid and awaiting retire
//   pc           address of instr
//   pc_plus4     pc + 4 (link value)
//   exec_done    core finished executing instr this cycle
//   stall        blocks new request and retire
//   Branch       taken branch
//   Jump         jal
//   jalr         jalr
//   ImmExt       sign-extended branch/jal offset
//   ALUResult    jalr target (rs1 + imm)
//   fetch_err    sticky error flag
//   instret      retired-instruction count
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        fetch_err,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    // Counter value seen on the last permitted REQ cycle without ack.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    // Word alignment check for a candidate PC.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        req_r;
    logic        valid_r;
    logic        err_r;
    logic [7:0]  cnt_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        retire_s;
    logic        target_ok_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-PC select (jalr > branch/jal > sequential) and retire qualification.
    always_comb begin
        next_pc_s   = pc_plus4_s;
        retire_s    = 1'b0;
        target_ok_s = 1'b1;
        if (jalr) begin
            next_pc_s = {ALUResult[31:1], 1'b0};
        end else if (Branch || Jump) begin
            next_pc_s = pc_r + ImmExt;
        end else begin
            next_pc_s = pc_plus4_s;
        end
        if ((state_r == HOLD) && exec_done && !stall) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
        target_ok_s = is_aligned(next_pc_s);
    end

    // Fetch FSM with registered request, instruction, valid and error outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            instr_r <= NOP_INSTR;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!stall) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                // stall is deliberately ignored here: a request is never withdrawn.
                REQ: begin
                    if (imem_ack) begin
                        instr_r <= imem_rdata;
                        valid_r <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= HOLD;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        req_r   <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                HOLD: begin
                    if (retire_s) begin
                        valid_r <= 1'b0;
                        if (target_ok_s) begin
                            pc_r    <= next_pc_s;
                            req_r   <= 1'b1;
                            cnt_r   <= 8'd0;
                            state_r <= REQ;
                        end else begin
                            // pc stays on the offending instruction for diagnosis.
                            err_r   <= 1'b1;
                            state_r <= ERR;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                ERR: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    err_r   <= 1'b1;
                    state_r <= ERR;
                end
                default: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    err_r   <= 1'b1;
                    state_r <= ERR;
                end
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] instret_r;
    logic        count_s;

    // Only a retire that actually advances the PC counts.
    assign count_s = retire_s && target_ok_s;

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_r <= 32'd0;
        end else if (count_s) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'h0000_0000;
`endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_err   = err_r;

endmodule
